ape_dec_sched: RTL and testbench

APE_DEC_SCHED -- requirements
Module: ape_dec_sched

---
 rtl/ape_dec_sched.sv | 130 +++++++++++++
 tb/tb_ape_dec_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ape_dec_sched.sv
// Two-requester burst scheduler feeding a single ciphertext decode register.
// Round-robin grant is locked per burst; bursts close on last or after MAX_BLK beats.
module ape_dec_sched #(
  parameter int unsigned MAX_BLK = 16
) (
  input  logic        clk_2,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [33:0] req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [33:0] req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        dec_valid,
  output logic [33:0] dec_data,
  input  logic        dec_ready,
  output logic [1:0]  grant,
  output logic        burst_done,
  output logic [7:0]  burst_cnt,
  output logic        burst_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_q, rr_d;          // 1: req1 has priority on a tie
  logic [7:0]  cnt_q, cnt_d;
  logic        dv_q, dv_d;
  logic [33:0] dd_q, dd_d;
  logic        done_q, done_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic        err_q, err_d;

  logic        slot_free, rdy0, rdy1, accept, pick1, hit_max;
  logic        in_last;
  logic [33:0] in_data;
  logic [8:0]  cnt_inc;

  // The decode slot can take a beat if it is empty or drains this cycle.
  assign slot_free = !dv_q || dec_ready;
  assign rdy0      = (state_q == BUSY) && grant_q[0] && slot_free;
  assign rdy1      = (state_q == BUSY) && grant_q[1] && slot_free;
  assign accept    = (rdy0 && req0_valid) || (rdy1 && req1_valid);
  assign in_data   = grant_q[1] ? req1_data : req0_data;
  assign in_last   = grant_q[1] ? req1_last : req0_last;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign hit_max   = (cnt_inc == 9'(MAX_BLK));
  assign pick1     = req1_valid && (!req0_valid || rr_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    done_d  = 1'b0;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;

    if (accept) begin
      dv_d = 1'b1;
      dd_d = in_data;
    end else if (dec_ready) begin
      dv_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Hold off a new owner until the previous burst's beat has left the slot.
        if ((req0_valid || req1_valid) && slot_free) begin
          state_d = BUSY;
          grant_d = pick1 ? 2'b10 : 2'b01;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (accept) begin
          cnt_d = cnt_inc[7:0];
          if (in_last || hit_max) begin
            state_d = IDLE;
            grant_d = 2'b00;
            rr_d    = grant_q[0];
            done_d  = 1'b1;
            bcnt_d  = cnt_inc[7:0];
            err_d   = !in_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      dv_q    <= 1'b0;
      dd_q    <= 34'd0;
      done_q  <= 1'b0;
      bcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready = rdy0;
  assign req1_ready = rdy1;
  assign dec_valid  = dv_q;
  assign dec_data   = dd_q;
  assign grant      = grant_q;
  assign burst_done = done_q;
  assign burst_cnt  = bcnt_q;
  assign burst_err  = err_q;

endmodule

// File: tb/tb_ape_dec_sched.sv
// Directed per-cycle vector bench for ape_dec_sched built with MAX_BLK = 4.
module tb_ape_dec_sched;

  logic        clk_2 = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [33:0] req0_data, req1_data, dec_data;
  logic        dec_valid, dec_ready;
  logic [1:0]  grant;
  logic        burst_done, burst_err;
  logic [7:0]  burst_cnt;

  ape_dec_sched #(.MAX_BLK(4)) dut (
    .clk_2(clk_2), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .grant(grant), .burst_done(burst_done), .burst_cnt(burst_cnt), .burst_err(burst_err)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct packed {
    logic        rst, v0;
    logic [33:0] d0;
    logic        l0, v1;
    logic [33:0] d1;
    logic        l1, dr;
  } in_t;

  typedef struct packed {
    logic        r0, r1, dv;
    logic [33:0] dd;
    logic [1:0]  g;
    logic        dn;
    logic [7:0]  cn;
    logic        er;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic out_t mk(input bit r0, input bit r1, input bit dv, input bit [33:0] dd,
                              input bit [1:0] g, input bit dn, input bit [7:0] cn, input bit er);
    out_t o;
    o = '{r0: r0, r1: r1, dv: dv, dd: dd, g: g, dn: dn, cn: cn, er: er};
    return o;
  endfunction

  task automatic add(input bit rst, input bit v0, input bit [33:0] d0, input bit l0,
                     input bit v1, input bit [33:0] d1, input bit l1, input bit dr,
                     input bit r0, input bit r1, input bit dv, input bit [33:0] dd,
                     input bit [1:0] g, input bit dn, input bit [7:0] cn, input bit er);
    vec_t v;
    v.i = '{rst: rst, v0: v0, d0: d0, l0: l0, v1: v1, d1: d1, l1: l1, dr: dr};
    v.o = mk(r0, r1, dv, dd, g, dn, cn, er);
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst_n      = i.rst;
    req0_valid = i.v0; req0_data = i.d0; req0_last = i.l0;
    req1_valid = i.v1; req1_data = i.d1; req1_last = i.l1;
    dec_ready  = i.dr;
  endtask

  task automatic cmp(input string name, input out_t e);
    out_t a;
    a = '{r0: req0_ready, r1: req1_ready, dv: dec_valid, dd: dec_data, g: grant,
          dn: burst_done, cn: burst_cnt, er: burst_err};
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got r0=%0b r1=%0b dv=%0b dd=%h g=%b done=%0b cnt=%0d err=%0b ; want r0=%0b r1=%0b dv=%0b dd=%h g=%b done=%0b cnt=%0d err=%0b",
                  name, a.r0, a.r1, a.dv, a.dd, a.g, a.dn, a.cn, a.er,
                  e.r0, e.r1, e.dv, e.dd, e.g, e.dn, e.cn, e.er);
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    // Three beats from req0, last on the third; reset values checked in row 0.
    add(1,0,0,0,0,0,0,1,     0,0,0,0,0,0,0,0);
    add(1,1,'h1,0,0,0,0,1,   0,0,0,0,0,0,0,0);
    add(1,1,'h1,0,0,0,0,1,   1,0,0,0,1,0,0,0);
    add(1,1,'h2,0,0,0,0,1,   1,0,1,'h1,1,0,0,0);
    add(1,1,'h3,1,0,0,0,1,   1,0,1,'h2,1,0,0,0);
    add(1,0,0,0,0,0,0,1,     0,0,1,'h3,0,1,3,0);
    add(1,0,0,0,0,0,0,1,     0,0,0,'h3,0,0,3,0);
    // Reset, then both requesters contend with 2-beat bursts: 01, 10, 01.
    add(0,0,0,0,0,0,0,1,     0,0,0,'h3,0,0,3,0);
    add(1,1,'h10,0,1,'h20,0,1, 0,0,0,0,0,0,0,0);
    add(1,1,'h10,0,1,'h20,0,1, 1,0,0,0,1,0,0,0);
    add(1,1,'h11,1,1,'h20,0,1, 1,0,1,'h10,1,0,0,0);
    add(1,1,'h12,0,1,'h20,0,1, 0,0,1,'h11,0,1,2,0);
    add(1,1,'h12,0,1,'h20,0,1, 0,1,0,'h11,2,0,2,0);
    add(1,1,'h12,0,1,'h21,1,1, 0,1,1,'h20,2,0,2,0);
    add(1,1,'h12,0,0,0,0,1,  0,0,1,'h21,0,1,2,0);
    add(1,1,'h12,0,0,0,0,1,  1,0,0,'h21,1,0,2,0);
    // Decode stalls four cycles mid-burst.
    for (int k = 0; k < 4; k++) add(1,1,'h13,0,0,0,0,0, 0,0,1,'h12,1,0,2,0);
    add(1,1,'h13,0,0,0,0,1,  1,0,1,'h12,1,0,2,0);
    add(1,1,'h14,1,0,0,0,1,  1,0,1,'h13,1,0,2,0);
    add(1,0,0,0,0,0,0,1,     0,0,1,'h14,0,1,3,0);
    add(1,0,0,0,0,0,0,1,     0,0,0,'h14,0,0,3,0);
    // req1 sends six beats; MAX_BLK=4 splits it into 4 (err) + 2.
    add(1,0,0,0,1,'h31,0,1,  0,0,0,'h14,0,0,3,0);
    add(1,0,0,0,1,'h31,0,1,  0,1,0,'h14,2,0,3,0);
    add(1,0,0,0,1,'h32,0,1,  0,1,1,'h31,2,0,3,0);
    add(1,0,0,0,1,'h33,0,1,  0,1,1,'h32,2,0,3,0);
    add(1,0,0,0,1,'h34,0,1,  0,1,1,'h33,2,0,3,0);
    add(1,0,0,0,1,'h35,0,1,  0,0,1,'h34,0,1,4,1);
    add(1,0,0,0,1,'h35,0,1,  0,1,0,'h34,2,0,4,0);
    add(1,0,0,0,1,'h36,1,1,  0,1,1,'h35,2,0,4,0);
    add(1,0,0,0,0,0,0,1,     0,0,1,'h36,0,1,2,0);
    add(1,0,0,0,0,0,0,1,     0,0,0,'h36,0,0,2,0);
    // Reset during req0's second beat; next burst counts from 1.
    add(1,1,'h41,0,0,0,0,1,  0,0,0,'h36,0,0,2,0);
    add(1,1,'h41,0,0,0,0,1,  1,0,0,'h36,1,0,2,0);
    add(0,1,'h42,0,0,0,0,1,  1,0,1,'h41,1,0,2,0);
    add(1,1,'h42,0,0,0,0,1,  0,0,0,0,0,0,0,0);
    add(1,1,'h42,0,0,0,0,1,  1,0,0,0,1,0,0,0);
    add(1,1,'h43,1,0,0,0,1,  1,0,1,'h42,1,0,0,0);
    add(1,0,0,0,0,0,0,1,     0,0,1,'h43,0,1,2,0);
    add(1,0,0,0,0,0,0,1,     0,0,0,'h43,0,0,2,0);

    drive('0);
    repeat (2) @(posedge clk_2);
    #1;

    foreach (vecs[n]) begin
      drive(vecs[n].i);
      #1;
      cmp($sformatf("vec%0d", n), vecs[n].o);
      step();
    end

    // One-beat burst left unconsumed: req1 must not be granted until it drains.
    drive('0); rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 34'h51; req0_last = 1'b1; dec_ready = 1'b0;
    #1 cmp("hold_idle", mk(0,0,0,'h43,0,0,2,0));
    step();
    cmp("one_beat_grant", mk(1,0,0,'h43,1,0,2,0));
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 34'h61; req1_last = 1'b1;
    #1 cmp("one_beat_done", mk(0,0,1,'h51,0,1,1,0));
    step();
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("no_regrant%0d", k), mk(0,0,1,'h51,0,0,1,0));
      step();
    end
    dec_ready = 1'b1;
    #1 cmp("drain", mk(0,0,1,'h51,0,0,1,0));
    step();
    cmp("req1_grant", mk(0,1,0,'h51,2,0,1,0));
    step();
    req1_valid = 1'b0;
    #1 cmp("req1_done", mk(0,0,1,'h61,0,1,1,0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
